// File: rtl/fdiv_iter_if.sv
// Operand/result handshake bundle for the iterative single-precision divider.
// master = FPU dispatcher side, slave = divider side.
interface fdiv_iter_if;
   logic [31:0] x1;
   logic [31:0] x2;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] y;
   logic        ovf;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output x1, x2, in_valid, out_ready,
      input  in_ready, y, ovf, out_valid
   );

   modport slave (
      input  x1, x2, in_valid, out_ready,
      output in_ready, y, ovf, out_valid
   );
endinterface

// File: rtl/fdiv_iter.sv
// Iterative truncating FP32 divider y = x1/x2, restoring mantissa division, one op in flight.
// Result valid 25/BITS_PER_CYCLE+2 cycles after accept; held in DONE until out_ready, input stalled meanwhile.
module fdiv_iter #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   fdiv_iter_if.slave  bus
);
   localparam int NSTEP = 25 / BITS_PER_CYCLE;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

   state_t             state;
   logic               sign;
   logic [7:0]         e1;
   logic [7:0]         e2;
   logic [24:0]        rem;
   logic [24:0]        rem_nx;
   logic [23:0]        dvs;
   logic [24:0]        q;
   logic [24:0]        q_nx;
   logic [CW-1:0]      cnt;
   logic [31:0]        y_r;
   logic [31:0]        y_nx;
   logic               ovf_r;
   logic               ovf_nx;
   logic               vld_r;
   logic [22:0]        mant;
   logic signed [9:0]  ye0;

   assign bus.in_ready  = (state == IDLE) & ~rst;
   assign bus.y         = y_r;
   assign bus.ovf       = ovf_r;
   assign bus.out_valid = vld_r;

   // rem stays below 2*dvs, so 25 bits hold it across the shift
   always_comb begin
      rem_nx = rem;
      q_nx   = q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (rem_nx >= {1'b0, dvs}) begin
            rem_nx = rem_nx - {1'b0, dvs};
            q_nx   = {q_nx[23:0], 1'b1};
         end else begin
            q_nx   = {q_nx[23:0], 1'b0};
         end
         rem_nx = {rem_nx[23:0], 1'b0};
      end
   end

   always_comb begin
      mant   = q[24] ? q[23:1] : q[22:0];
      ye0    = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127
               - $signed({9'd0, ~q[24]});
      y_nx   = {sign, ye0[7:0], mant};
      ovf_nx = 1'b0;
      if (e1 == 8'h00) begin
         y_nx = {sign, 31'b0};
      end else if (e2 == 8'hFF) begin
         y_nx = {sign, 31'b0};
      end else if (e1 == 8'hFF) begin
         y_nx = {sign, 8'hFF, 23'b0};
      end else if (e2 == 8'h00) begin
         y_nx = {sign, 8'hFF, 23'b0};
      end else if (ye0 >= 10'sd255) begin
         y_nx   = {sign, 8'hFF, 23'b0};
         ovf_nx = 1'b1;
      end else if (ye0 <= 10'sd0) begin
         y_nx = {sign, 31'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sign  <= 1'b0;
         e1    <= '0;
         e2    <= '0;
         rem   <= '0;
         dvs   <= '0;
         q     <= '0;
         cnt   <= '0;
         y_r   <= '0;
         ovf_r <= 1'b0;
         vld_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign  <= bus.x1[31] ^ bus.x2[31];
                  e1    <= bus.x1[30:23];
                  e2    <= bus.x2[30:23];
                  rem   <= {2'b01, bus.x1[22:0]};
                  dvs   <= {1'b1, bus.x2[22:0]};
                  q     <= '0;
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               rem <= rem_nx;
               q   <= q_nx;
               if (cnt == CW'(NSTEP - 1)) begin
                  cnt   <= '0;
                  state <= NORM;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            NORM: begin
               y_r   <= y_nx;
               ovf_r <= ovf_nx;
               vld_r <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  vld_r <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
